// File: rtl/mem_fill_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_fill_responder
//  Description : Multi-cycle main-memory model behind the cache miss path.
//                Serves 8-word block fills (pipelined, fixed first-word
//                latency) and single-word write-through stores.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_fill_responder #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int LATENCY         = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_write,
  input  logic [ADDR_W-1:0]                  req_addr,
  input  logic [DATA_W-1:0]                  req_wdata,
  output logic                               rsp_valid,
  output logic [DATA_W-1:0]                  rsp_data,
  output logic [ADDR_W-1:0]                  rsp_addr,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] rsp_idx,
  output logic                               rsp_last,
  output logic                               wr_done,
  output logic                               busy
);

  localparam int IDX_W   = $clog2(WORDS_PER_BLOCK);
  localparam int WADDR_W = ADDR_W - 1;           // word address width
  localparam int BLK_W   = WADDR_W - IDX_W;      // block number width
  localparam int DEPTH   = 1 << WADDR_W;
  localparam int WCNT_W  = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Word storage; deliberately outside the reset domain.
  logic [DATA_W-1:0] mem [DEPTH];

  state_t             state_q,     state_d;
  logic [BLK_W-1:0]   blk_q,       blk_d;
  logic [IDX_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic               issuing_q,   issuing_d;
  logic [WCNT_W-1:0]  wcnt_q,      wcnt_d;

  // Fill delay line: stage 0 is loaded at issue, the last stage drives rsp_*.
  logic               pipe_valid_q [LATENCY];
  logic               pipe_valid_d [LATENCY];
  logic [IDX_W-1:0]   pipe_idx_q   [LATENCY];
  logic [IDX_W-1:0]   pipe_idx_d   [LATENCY];
  logic [DATA_W-1:0]  pipe_data_q  [LATENCY];
  logic [DATA_W-1:0]  pipe_data_d  [LATENCY];

  logic               accept;
  logic               accept_rd;
  logic               accept_wr;
  logic               issue_en;
  logic [BLK_W-1:0]   issue_blk;
  logic [IDX_W-1:0]   issue_idx;
  logic [DATA_W-1:0]  issue_data;

  // A request is never taken while reset is being applied.
  assign req_ready = (state_q == S_IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready & ~rst_n;
  assign accept_rd = accept & ~req_write;
  assign accept_wr = accept & req_write;

  // Word 0 issues on the accepting edge straight from the request so the
  // first word lands exactly LATENCY cycles later; the rest come from blk_q.
  assign issue_en   = accept_rd | issuing_q;
  assign issue_blk  = accept_rd ? req_addr[ADDR_W-1:IDX_W+1] : blk_q;
  assign issue_idx  = accept_rd ? '0 : issue_cnt_q;
  assign issue_data = mem[{issue_blk, issue_idx}];

  assign rsp_valid = pipe_valid_q[LATENCY-1];
  assign rsp_idx   = pipe_idx_q[LATENCY-1];
  assign rsp_data  = pipe_data_q[LATENCY-1];
  assign rsp_addr  = rsp_valid ? {blk_q, rsp_idx, 1'b0} : '0;
  assign rsp_last  = rsp_valid & (rsp_idx == IDX_W'(WORDS_PER_BLOCK - 1));
  assign wr_done   = (state_q == S_WRITE) & (wcnt_q == WCNT_W'(LATENCY - 1));

  // Next-state, issue counter and write-latency counter.
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    wcnt_d      = wcnt_q;
    issue_cnt_d = issue_cnt_q;
    issuing_d   = issuing_q;
    case (state_q)
      S_IDLE: begin
        if (accept_rd) begin
          state_d = S_FILL;
          blk_d   = req_addr[ADDR_W-1:IDX_W+1];
        end else if (accept_wr) begin
          state_d = S_WRITE;
          wcnt_d  = '0;
        end
      end
      S_FILL: begin
        if (rsp_last) state_d = S_IDLE;
      end
      S_WRITE: begin
        if (wr_done) state_d = S_IDLE;
        else         wcnt_d  = wcnt_q + WCNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (issue_en) begin
      issue_cnt_d = issue_idx + IDX_W'(1);
      issuing_d   = (issue_idx != IDX_W'(WORDS_PER_BLOCK - 1));
    end
  end

  // Shift the fill pipeline; idle slots carry zeros so outputs read 0.
  always_comb begin
    for (int k = 0; k < LATENCY; k++) begin
      pipe_valid_d[k] = 1'b0;
      pipe_idx_d[k]   = '0;
      pipe_data_d[k]  = '0;
    end
    pipe_valid_d[0] = issue_en;
    pipe_idx_d[0]   = issue_en ? issue_idx  : '0;
    pipe_data_d[0]  = issue_en ? issue_data : '0;
    for (int k = 1; k < LATENCY; k++) begin
      pipe_valid_d[k] = pipe_valid_q[k-1];
      pipe_idx_d[k]   = pipe_idx_q[k-1];
      pipe_data_d[k]  = pipe_data_q[k-1];
    end
  end

  // Control and pipeline registers; reset (active-high rst_n) aborts any fill.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      blk_q       <= '0;
      issue_cnt_q <= '0;
      issuing_q   <= 1'b0;
      wcnt_q      <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        pipe_valid_q[k] <= 1'b0;
        pipe_idx_q[k]   <= '0;
        pipe_data_q[k]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      issue_cnt_q <= issue_cnt_d;
      issuing_q   <= issuing_d;
      wcnt_q      <= wcnt_d;
      for (int k = 0; k < LATENCY; k++) begin
        pipe_valid_q[k] <= pipe_valid_d[k];
        pipe_idx_q[k]   <= pipe_idx_d[k];
        pipe_data_q[k]  <= pipe_data_d[k];
      end
    end
  end

  // Memory commits on the accepting edge, so a later reset cannot undo it.
  always_ff @(posedge clk) begin
    if (accept_wr) mem[req_addr[ADDR_W-1:1]] <= req_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_fill_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_fill_responder
//  Description : Directed self-checking bench with a response scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_fill_responder;

  localparam int WPB = 8;
  localparam int LAT = 4;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr  = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] rsp_addr;
  logic [2:0]  rsp_idx;
  logic        rsp_last;
  logic        wr_done;
  logic        busy;

  mem_fill_responder #(
    .ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(WPB), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .rsp_idx(rsp_idx), .rsp_last(rsp_last), .wr_done(wr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int acc;

  logic [15:0] model [32768];

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [15:0] addr;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   wr_q[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the cycle in which the held request is accepted.
  task automatic wait_accept(output int a);
    bit got;
    got = 1'b0;
    a   = -1;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        a   = cyc;
      end
    end
    chk("accept_seen", {31'd0, got}, 32'd1);
  endtask

  // Present a request, record expected outcomes once it is accepted.
  task automatic issue(input bit wr, input logic [15:0] a, input logic [15:0] d, input bit drop);
    int          t;
    logic [15:0] base;
    exp_t        e;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    wait_accept(t);
    acc = t;
    if (wr) begin
      model[a[15:1]] = d;
      wr_q.push_back(t + LAT);
    end else begin
      base = {a[15:4], 4'h0};
      for (int i = 0; i < WPB; i++) begin
        e.cyc  = t + LAT + i;
        e.addr = base + 16'(2 * i);
        e.data = model[e.addr[15:1]];
        e.idx  = 3'(i);
        e.last = (i == WPB - 1);
        exp_q.push_back(e);
      end
    end
    if (drop) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  // Scoreboard: every response / write completion is matched in order and time.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_cycle", cyc, mon_e.cyc);
          chk("rsp_data", {16'd0, rsp_data}, {16'd0, mon_e.data});
          chk("rsp_addr", {16'd0, rsp_addr}, {16'd0, mon_e.addr});
          chk("rsp_idx", {29'd0, rsp_idx}, {29'd0, mon_e.idx});
          chk("rsp_last", {31'd0, rsp_last}, {31'd0, mon_e.last});
        end
      end else begin
        chk("idle_addr_data", {rsp_addr, rsp_data}, 32'd0);
        chk("idle_idx_last", {28'd0, rsp_idx, rsp_last}, 32'd0);
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          chk("rsp_missing", {31'd0, rsp_valid}, 32'd1);
          void'(exp_q.pop_front());
        end
      end
      if (wr_done) begin
        if (wr_q.size() == 0) begin
          chk("wr_done_unexpected", {31'd0, wr_done}, 32'd0);
        end else begin
          chk("wr_done_cycle", cyc, wr_q.pop_front());
        end
      end else if (wr_q.size() > 0 && wr_q[0] <= cyc) begin
        chk("wr_done_missing", {31'd0, wr_done}, 32'd1);
        void'(wr_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    bit got;
    for (int i = 0; i < 32768; i++) model[i] = '0;

    // Reset held for two edges, then released.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_wr_done", {31'd0, wr_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Write then fill of the same block (unaligned fill address).
    issue(1'b1, 16'h0046, 16'h1234, 1'b1);
    issue(1'b0, 16'h0047, 16'h0000, 1'b1);

    // Back-to-back fills: the second is held from the cycle after the first.
    issue(1'b1, 16'h0104, 16'hA5A5, 1'b1);
    issue(1'b1, 16'h0202, 16'h5A5A, 1'b1);
    issue(1'b0, 16'h0100, 16'h0000, 1'b0);
    a1 = acc;
    @(posedge clk); #1;
    req_addr = 16'h0200;
    for (int k = 1; k <= LAT + WPB - 1; k++) begin
      @(negedge clk);
      chk("b2b_ready_low", {31'd0, req_ready}, 32'd0);
      chk("b2b_busy_high", {31'd0, busy}, 32'd1);
    end
    issue(1'b0, 16'h0200, 16'h0000, 1'b1);
    chk("b2b_accept_cycle", acc, a1 + LAT + WPB);

    // A write pulsed while busy must be dropped entirely.
    issue(1'b0, 16'h0300, 16'h0000, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0302; req_wdata = 16'hDEAD;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
    issue(1'b0, 16'h0300, 16'h0000, 1'b1);

    // Reset after the third word of a fill.
    issue(1'b0, 16'h0040, 16'h0000, 1'b1);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid && rsp_idx == 3'd2) got = 1'b1;
    end
    chk("mid_fill_word2_seen", {31'd0, got}, 32'd1);
    #1 rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("midrst_quiet", {31'd0, rsp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    issue(1'b0, 16'h0040, 16'h0000, 1'b1);

    // Highest block in memory.
    issue(1'b1, 16'hFFFE, 16'hBEEF, 1'b1);
    issue(1'b0, 16'hFFF0, 16'h0000, 1'b1);

    // Drain and confirm nothing expected was left unseen.
    for (int n = 0; n < 100 && (exp_q.size() > 0 || wr_q.size() > 0); n++) @(negedge clk);
    chk("drain_rsp", exp_q.size(), 32'd0);
    chk("drain_wr", wr_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_fill_responder.md
Name: mem_fill_responder

Overview:
- Multi-cycle main-memory model on the responder side of the cache-miss interface.
- The I-cache and D-cache miss controllers issue block-fill reads and write-through word writes to it.
- Each fill returns the 8 words of a 16-byte block, pipelined: the first word arrives LATENCY cycles after acceptance, then one word per cycle.
- Sits below the cache arbiter; replaces the single-cycle memory behind the fetch and memory stages.

Parameters:
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width.
- WORDS_PER_BLOCK, 8, words returned per fill; power of 2.
- LATENCY, 4, cycles from request acceptance to the first response word; must be at least 1.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous reset, active-high (1 = reset).
- req_valid, input, 1, request present.
- req_ready, output, 1, responder can accept a request this cycle.
- req_write, input, 1, 1 = single-word write, 0 = block fill read.
- req_addr, input, ADDR_W, byte address.
- req_wdata, input, DATA_W, write data.
- rsp_valid, output, 1, response word valid.
- rsp_data, output, DATA_W, response word.
- rsp_addr, output, ADDR_W, byte address of rsp_data.
- rsp_idx, output, log2(WORDS_PER_BLOCK), word index within the block.
- rsp_last, output, 1, final word of a fill.
- wr_done, output, 1, one-cycle pulse when a write completes.
- busy, output, 1, equal to ~req_ready.

Behaviour:
- Storage:
  - 2^(ADDR_W-1) words, word index = addr[ADDR_W-1:1]; byte address bit 0 is ignored everywhere.
  - Contents are zero at time 0.
  - Contents are NOT cleared by rst_n.
- Handshake:
  - A request is accepted on a rising edge where req_valid & req_ready; call that edge T.
  - req_ready is 1 only in IDLE.
  - Requests presented while req_ready = 0 are ignored and are not queued.
  - The requester holds req_* stable until accepted.
- State machine: IDLE, FILL, WRITE.
  - IDLE -> FILL on an accepted read.
  - IDLE -> WRITE on an accepted write.
  - FILL -> IDLE on the edge ending the rsp_last cycle.
  - WRITE -> IDLE on the edge ending the wr_done cycle.
- Fill timing:
  - Block base = {req_addr[ADDR_W-1:4], 4'b0}; req_addr[3:0] is ignored and no critical-word-first reordering is done.
  - Word i (i = 0..7) is read from base + 2i.
  - Word i appears with rsp_valid = 1 in the cycle after edge T+LATENCY-1+i, i.e. LATENCY cycles after acceptance, then consecutively.
  - rsp_addr = base + 2i, rsp_idx = i, rsp_last = (i == 7).
  - rsp_valid is contiguous for exactly 8 cycles; there is no backpressure and the requester must sink every word.
  - req_ready returns to 1 in the cycle after rsp_last, so a new request can be accepted at the earliest 1 cycle after the last word.
  - Fill occupancy: LATENCY+8 cycles from acceptance to ready.
- Fill implementation:
  - Word issue uses a 3-bit issue counter feeding a LATENCY-deep shift pipeline of {valid, idx, data}.
  - Data is sampled at issue; a write cannot land mid-fill, so there are no coherence hazards.
- Write timing:
  - The memory word at req_addr[ADDR_W-1:1] is updated on edge T; the value is visible to any later fill.
  - wr_done = 1 in the cycle after edge T+LATENCY-1.
  - No rsp_valid is produced for writes.
  - Write occupancy: LATENCY cycles busy, then IDLE.
- Idle outputs:
  - rsp_data, rsp_addr and rsp_idx are 0 whenever rsp_valid = 0.
  - rsp_last and wr_done are 0 unless stated above.
- Reset (rst_n = 1 at an edge):
  - Next cycle: state IDLE, req_ready = 1, busy = 0, rsp_valid = rsp_last = wr_done = 0, rsp_data = rsp_addr = rsp_idx = 0.
  - The pipeline and counters are cleared.
  - An in-flight fill is aborted with no further words.
  - A write already accepted stays committed to memory, but its wr_done is suppressed.
  - A request presented during a reset cycle is not accepted.
- Address wrap: the block base is aligned, so a fill never crosses the top of memory; the highest block 0xFFF0 returns 0xFFF0..0xFFFE.

Test Plan:
- Reset: hold rst_n = 1 for 2 cycles, then release -> req_ready = 1, rsp_valid = 0, wr_done = 0, busy = 0.
- Write then fill:
  - Write 0x1234 to 0x0046 -> wr_done pulses exactly 4 cycles after acceptance.
  - Then fill 0x0047 -> 8 words with rsp_addr 0x0040..0x004E; the word with rsp_idx = 3 has rsp_data = 0x1234 and the others are 0.
  - The first rsp_valid is 4 cycles after acceptance; rsp_last is on idx 7.
- Fill timing and back-to-back:
  - Fill accepted at cycle 10 -> rsp_valid in cycles 14..21; req_ready = 0 during cycles 11..21 and 1 in cycle 22.
  - A second fill held with req_valid = 1 from cycle 11 is accepted at cycle 22, and its first word appears in cycle 26.
- Ignored request: pulse req_valid with a write for 1 cycle while busy (cycle 15 of a fill) -> memory is unchanged and no wr_done occurs.
- Reset mid-fill:
  - Assert rst_n after the 3rd response word -> rsp_valid = 0 the next cycle and stays 0.
  - req_ready = 1 after release.
  - A subsequent fill of the same block returns the correct data.
- Top block: write 0xBEEF to 0xFFFE, then fill 0xFFF0 -> rsp_idx 7 has rsp_addr 0xFFFE and rsp_data 0xBEEF, with rsp_last = 1.
